// File: rtl/zeroriscy_sram_pkg.sv
// Shared types, LFSR constants and the address decoder for the zero-riscy multi-port SRAM model.
// No logic of its own; imported by the SRAM top and its response pipeline.
package zeroriscy_sram_pkg;

  typedef enum logic [1:0] {REG_IMEM, REG_DMEM, REG_MISS} region_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as a mask over lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Region compare is done in 33 bits so a region ending at 4 GiB does not wrap.
  function automatic region_e decode_addr(logic [31:0] a, logic [31:0] ibase, int unsigned iwords,
                                          logic [31:0] dbase, int unsigned nwords);
    logic [32:0] x;
    logic [32:0] ilo;
    logic [32:0] dlo;
    x   = {1'b0, a};
    ilo = {1'b0, ibase};
    dlo = {1'b0, dbase};
    if (x >= ilo && x < ilo + {iwords[30:0], 2'b00}) return REG_IMEM;
    if (x >= dlo && x < dlo + {nwords[30:0], 2'b00}) return REG_DMEM;
    return REG_MISS;
  endfunction

endpackage

// File: rtl/zeroriscy_sram_resp_pipe.sv
// Per-port response delay line of resp_t, RLAT stages deep, cleared by synchronous reset.
// Latency: RLAT cycles from capture to out_resp. No backpressure: one entry shifts every cycle.
module zeroriscy_sram_resp_pipe
  import zeroriscy_sram_pkg::*;
#(
  parameter int RLAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RESP_W-1:0] in_resp,
  output logic [RESP_W-1:0] out_resp
);

  resp_t stage [RLAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < RLAT; s++) stage[s] <= '0;
    end else begin
      stage[0] <= in_resp;
      for (int s = 1; s < RLAT; s++) stage[s] <= stage[s-1];
    end
  end

  assign out_resp = stage[RLAT-1];

endmodule

// File: rtl/zeroriscy_mp_sram.sv
// Multi-port behavioural SRAM (instruction + data regions) for zero-riscy benches; RLAT-cycle responses.
// Backpressure: gnt tied high by default; with ZR_SRAM_STALL_EN a per-port LFSR drops gnt ~25% of cycles.
module zeroriscy_mp_sram
  import zeroriscy_sram_pkg::*;
#(
  parameter int          NPORTS = 2,
  parameter int          IWORDS = 4096,
  parameter int          NWORDS = 131072,
  parameter logic [31:0] IBASE  = 32'h0000_0000,
  parameter logic [31:0] DBASE  = 32'h0010_0000,
  parameter int          RLAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORTS-1:0]      req,
  input  logic [NPORTS-1:0]      we,
  input  logic [4*NPORTS-1:0]    be,
  input  logic [32*NPORTS-1:0]   addr,
  input  logic [32*NPORTS-1:0]   wdata,
  output logic [32*NPORTS-1:0]   rdata,
  output logic [NPORTS-1:0]      gnt,
  output logic [NPORTS-1:0]      rvalid,
  output logic [NPORTS-1:0]      err
);

  localparam int IAW = (IWORDS > 1) ? $clog2(IWORDS) : 1;
  localparam int DAW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [31:0]     imem [IWORDS];
  logic [31:0]     dmem [NWORDS];

  region_e         region  [NPORTS];
  logic [IAW-1:0]  iidx    [NPORTS];
  logic [DAW-1:0]  didx    [NPORTS];
  resp_t           resp_in [NPORTS];
  logic [NPORTS-1:0] acc;

`ifdef ZR_SRAM_STALL_EN
  logic [15:0] lfsr [NPORTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (!rst_n) lfsr[i] <= LFSR_SEED ^ 16'(i << 4);
      else        lfsr[i] <= {lfsr[i][14:0], ^(lfsr[i] & LFSR_TAPS)};
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NPORTS; i++) gnt[i] = ~(lfsr[i][1] & lfsr[i][0]);
  end
`else
  assign gnt = {NPORTS{1'b1}};
`endif

  assign acc = req & gnt;

  // Reads see the array before this edge's writes, so read-during-write returns old data.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      region[i]       = decode_addr(addr[32*i +: 32], IBASE, IWORDS, DBASE, NWORDS);
      iidx[i]         = IAW'((addr[32*i +: 32] - IBASE) >> 2);
      didx[i]         = DAW'((addr[32*i +: 32] - DBASE) >> 2);
      resp_in[i]      = '0;
      resp_in[i].valid = acc[i];
      resp_in[i].err   = acc[i] && (region[i] == REG_MISS);
      if (acc[i] && !we[i]) begin
        if (region[i] == REG_IMEM)      resp_in[i].data = imem[iidx[i]];
        else if (region[i] == REG_DMEM) resp_in[i].data = dmem[didx[i]];
      end
    end
  end

  // Highest port is applied first so the lowest-indexed writer of each byte lands last and wins.
  always_ff @(posedge clk) begin
    for (int i = NPORTS-1; i >= 0; i--) begin
      if (acc[i] && we[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[4*i + b]) begin
            if (region[i] == REG_IMEM)      imem[iidx[i]][8*b +: 8] <= wdata[32*i + 8*b +: 8];
            else if (region[i] == REG_DMEM) dmem[didx[i]][8*b +: 8] <= wdata[32*i + 8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic [RESP_W-1:0] out_w;
    resp_t             out_r;

    zeroriscy_sram_resp_pipe #(.RLAT(RLAT)) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_resp  (resp_in[i]),
      .out_resp (out_w)
    );

    assign out_r              = out_w;
    assign rvalid[i]          = out_r.valid;
    assign err[i]             = out_r.err;
    assign rdata[32*i +: 32]  = out_r.data;
  end

endmodule

// File: tb/tb_zeroriscy_mp_sram.sv
// Self-checking bench: directed vector table, collision/latency/reset sequences and a randomized
// run against a word-level memory model; an RLAT=1 and an RLAT=3 instance share clock and reset.
module tb_zeroriscy_mp_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req1, we1, gnt1, rvalid1, err1;
  logic [7:0]  be1;
  logic [63:0] addr1, wdata1, rdata1;
  logic [1:0]  req3, we3, gnt3, rvalid3, err3;
  logic [7:0]  be3;
  logic [63:0] addr3, wdata3, rdata3;

  zeroriscy_mp_sram #(.NPORTS(2), .RLAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .be(be1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .gnt(gnt1), .rvalid(rvalid1), .err(err1)
  );

  zeroriscy_mp_sram #(.NPORTS(2), .NWORDS(1024), .RLAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .be(be3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .gnt(gnt3), .rvalid(rvalid3), .err(err3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [16];

  // Reference model: word contents keyed by aligned byte address.
  logic [31:0] mdl [logic [31:0]];
  logic        rr [2];
  logic        ww [2];
  logic [3:0]  bb [2];
  logic [31:0] aa [2];
  logic [31:0] dd [2];
  logic        pend [2];
  logic        perr [2];
  logic [31:0] pdat [2];
  logic [31:0] tmp;
  bit          shadowed;
  int          acc_cyc [$];
  logic [31:0] expd [$];
  int          n, nrv, nacc, issued, seen;
  bit          saw_low;
  logic        exp_v;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_hit(logic [31:0] a);
    return (a < 32'h0000_4000) || (a >= 32'h0010_0000 && a < 32'h0018_0000);
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] w;
    logic [31:0] lo;
    int          c;
    w  = 32'($urandom_range(0, 7)) << 2;
    lo = 32'($urandom_range(0, 3));
    c  = $urandom_range(0, 8);
    if (c < 4) return w | lo;
    if (c < 8) return 32'h0010_0000 + w + lo;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_4000;
      1:       return 32'h0008_0000;
      2:       return 32'h0018_0000;
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  task automatic drv1(int p, logic r, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d);
    req1[p]           = r;
    we1[p]            = w;
    be1[4*p +: 4]     = b;
    addr1[32*p +: 32] = a;
    wdata1[32*p +: 32] = d;
  endtask

  // Single access on the RLAT=1 instance; response must appear exactly one cycle after accept.
  task automatic op1(string nm, int p, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d,
                     logic ee, logic [31:0] ed);
    int k;
    k = 0;
    while (!gnt1[p] && k < 64) begin @(negedge clk); k++; end
    chk({nm, " gnt wait"}, 32'(k < 64), 32'd1);
    drv1(p, 1'b1, w, b, a, d);
    @(negedge clk);
    drv1(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk({nm, " rvalid"}, 32'(rvalid1[p]), 32'd1);
    chk({nm, " err"}, 32'(err1[p]), 32'(ee));
    chk({nm, " rdata"}, rdata1[32*p +: 32], ed);
    @(negedge clk);
    chk({nm, " rvalid one cycle"}, 32'(rvalid1[p]), 32'd0);
  endtask

  // Both ports accepted on the same edge; write responses carry zero data.
  task automatic pair(string nm, logic w0, logic [3:0] b0, logic [31:0] a0, logic [31:0] d0,
                      logic w1, logic [3:0] b1, logic [31:0] a1, logic [31:0] d1,
                      logic [31:0] e0, logic [31:0] e1);
    int k;
    k = 0;
    while (gnt1 != 2'b11 && k < 64) begin @(negedge clk); k++; end
    chk({nm, " gnt wait"}, 32'(k < 64), 32'd1);
    drv1(0, 1'b1, w0, b0, a0, d0);
    drv1(1, 1'b1, w1, b1, a1, d1);
    @(negedge clk);
    drv1(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv1(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk({nm, " rvalid"}, 32'(rvalid1), 32'h3);
    chk({nm, " rdata p0"}, rdata1[31:0], e0);
    chk({nm, " rdata p1"}, rdata1[63:32], e1);
    @(negedge clk);
  endtask

  task automatic rand_check();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rand rvalid p%0d", p), 32'(rvalid1[p]), 32'(pend[p]));
      if (pend[p] && rvalid1[p]) begin
        chk($sformatf("rand err p%0d", p), 32'(err1[p]), 32'(perr[p]));
        chk($sformatf("rand rdata p%0d", p), rdata1[32*p +: 32], pdat[p]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 1'b1, 4'hF, 32'h0010_0040, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b0, 4'hF, 32'h0010_0040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         1'b0, 32'h11BB_33DD};
    tbl[5]  = '{1, 1'b0, 4'hF, 32'h0008_0000, 32'h0,         1'b1, 32'h0};
    tbl[6]  = '{0, 1'b1, 4'hF, 32'h0008_0000, 32'h1234_5678, 1'b1, 32'h0};
    tbl[7]  = '{1, 1'b1, 4'h0, 32'h0010_0040, 32'h0BAD_0BAD, 1'b0, 32'h0};
    tbl[8]  = '{0, 1'b0, 4'hF, 32'h0010_0043, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[9]  = '{0, 1'b1, 4'hF, 32'h0000_3FFC, 32'h0BAD_F00D, 1'b0, 32'h0};
    tbl[10] = '{1, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0,         1'b0, 32'h0BAD_F00D};
    tbl[11] = '{0, 1'b0, 4'hF, 32'h0000_4000, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{1, 1'b1, 4'hF, 32'h0017_FFFC, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[13] = '{1, 1'b0, 4'hF, 32'h0017_FFFC, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[14] = '{0, 1'b0, 4'hF, 32'h0018_0000, 32'h0,         1'b1, 32'h0};
    tbl[15] = '{0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

    rst_n = 1'b0;
    req1 = '0; we1 = '0; be1 = '0; addr1 = '0; wdata1 = '0;
    req3 = '0; we3 = '0; be3 = '0; addr3 = '0; wdata3 = '0;
    repeat (3) @(negedge clk);
    chk("reset rvalid1", 32'(rvalid1), 32'h0);
    chk("reset err1", 32'(err1), 32'h0);
    chk("reset rdata1 lo", rdata1[31:0], 32'h0);
    chk("reset rdata1 hi", rdata1[63:32], 32'h0);
    chk("reset rvalid3", 32'(rvalid3), 32'h0);
    chk("reset err3", 32'(err3), 32'h0);
    chk("reset rdata3 lo", rdata3[31:0], 32'h0);
    chk("reset rdata3 hi", rdata3[63:32], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef ZR_SRAM_STALL_EN
    chk("gnt tied high", {28'h0, gnt3, gnt1}, 32'hF);
`endif

    for (int i = 0; i < 16; i++)
      op1($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
          tbl[i].exp_err, tbl[i].exp_rdata);

    pair("coll1", 1'b1, 4'b0001, 32'h0010_0000, 32'h0000_00FF,
                  1'b1, 4'b1111, 32'h0010_0000, 32'hFFFF_FF00, 32'h0, 32'h0);
    op1("coll1 rd", 0, 1'b0, 4'hF, 32'h0010_0000, 32'h0, 1'b0, 32'hFFFF_FFFF);
    pair("coll2", 1'b1, 4'b0011, 32'h0010_0000, 32'h0000_00FF,
                  1'b1, 4'b1111, 32'h0010_0000, 32'hFFFF_FF00, 32'h0, 32'h0);
    op1("coll2 rd", 1, 1'b0, 4'hF, 32'h0010_0000, 32'h0, 1'b0, 32'hFFFF_00FF);

    op1("rdw init", 0, 1'b1, 4'hF, 32'h0010_0080, 32'h1111_1111, 1'b0, 32'h0);
    pair("rdw", 1'b1, 4'hF, 32'h0010_0080, 32'h2222_2222,
                1'b0, 4'hF, 32'h0010_0080, 32'h0, 32'h0, 32'h1111_1111);
    op1("rdw new", 1, 1'b0, 4'hF, 32'h0010_0080, 32'h0, 1'b0, 32'h2222_2222);

    // Randomized traffic on both ports of the RLAT=1 instance.
    for (int k = 0; k < 8; k++) begin
      tmp = $urandom();
      op1("pre imem", 0, 1'b1, 4'hF, 32'(k * 4), tmp, 1'b0, 32'h0);
      mdl[32'(k * 4)] = tmp;
      tmp = $urandom();
      op1("pre dmem", 1, 1'b1, 4'hF, 32'h0010_0000 + 32'(k * 4), tmp, 1'b0, 32'h0);
      mdl[32'h0010_0000 + 32'(k * 4)] = tmp;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int t = 0; t < 400; t++) begin
      rand_check();
      for (int p = 0; p < 2; p++) begin
        rr[p] = ($urandom_range(0, 3) != 0) && gnt1[p];
        ww[p] = 1'($urandom_range(0, 1));
        bb[p] = 4'($urandom_range(0, 15));
        aa[p] = rnd_addr();
        dd[p] = $urandom();
        drv1(p, rr[p], ww[p], bb[p], aa[p], dd[p]);
        pend[p] = rr[p];
        perr[p] = rr[p] && !is_hit(aa[p]);
        pdat[p] = (rr[p] && !ww[p] && is_hit(aa[p])) ? mdl[{aa[p][31:2], 2'b00}] : 32'h0;
      end
      for (int p = 0; p < 2; p++) begin
        if (rr[p] && ww[p] && is_hit(aa[p])) begin
          for (int k = 0; k < 4; k++) begin
            if (bb[p][k]) begin
              shadowed = 1'b0;
              for (int q = 0; q < p; q++)
                if (rr[q] && ww[q] && is_hit(aa[q]) && aa[q][31:2] == aa[p][31:2] && bb[q][k])
                  shadowed = 1'b1;
              if (!shadowed) begin
                tmp = mdl[{aa[p][31:2], 2'b00}];
                tmp[8*k +: 8] = dd[p][8*k +: 8];
                mdl[{aa[p][31:2], 2'b00}] = tmp;
              end
            end
          end
        end
      end
      @(negedge clk);
    end
    rand_check();
    drv1(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv1(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge clk);
    rand_check();

    // RLAT=3: preload four words, then issue reads as fast as gnt allows.
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!gnt3[0] && n < 64) begin @(negedge clk); n++; end
      req3[0] = 1'b1; we3[0] = 1'b1; be3[3:0] = 4'hF;
      addr3[31:0] = 32'h0010_0000 + 32'(k * 4); wdata3[31:0] = 32'hC0DE_0000 + 32'(k);
      @(negedge clk);
      req3[0] = 1'b0; we3[0] = 1'b0;
    end
    repeat (5) @(negedge clk);
    issued = 0; seen = 0;
    for (int t = 0; t < 40; t++) begin
      exp_v = (acc_cyc.size() > 0) && (acc_cyc[0] + 2 == cyc);
      chk("rlat3 rvalid", 32'(rvalid3[0]), 32'(exp_v));
      if (exp_v) begin
        chk("rlat3 rdata", rdata3[31:0], expd[0]);
        chk("rlat3 err", 32'(err3[0]), 32'h0);
        void'(acc_cyc.pop_front());
        void'(expd.pop_front());
        seen++;
      end
      if (issued < 4 && gnt3[0]) begin
        req3[0] = 1'b1; we3[0] = 1'b0;
        addr3[31:0] = 32'h0010_0000 + 32'(issued * 4);
        acc_cyc.push_back(cyc + 1);
        expd.push_back(32'hC0DE_0000 + 32'(issued));
        issued++;
      end else begin
        req3[0] = 1'b0;
      end
      @(negedge clk);
    end
    chk("rlat3 responses", 32'(seen), 32'd4);

    // Reset the cycle after an accept: that response must never appear.
    n = 0;
    while (!gnt3[0] && n < 64) begin @(negedge clk); n++; end
    req3[0] = 1'b1; we3[0] = 1'b0; addr3[31:0] = 32'h0010_0000;
    @(negedge clk);
    req3[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    repeat (8) begin
      if (rvalid3[0]) nrv++;
      @(negedge clk);
    end
    chk("reset drops in-flight", 32'(nrv), 32'd0);
    op1("mem survives reset", 0, 1'b0, 4'hF, 32'h0010_0040, 32'h0, 1'b0, 32'hDEAD_BEEF);

`ifdef ZR_SRAM_STALL_EN
    nacc = 0; nrv = 0; saw_low = 1'b0;
    drv1(0, 1'b1, 1'b0, 4'hF, 32'h0010_0040, 32'h0);
    for (int t = 0; t < 200; t++) begin
      if (rvalid1[0]) nrv++;
      if (gnt1[0]) nacc++;
      else saw_low = 1'b1;
      @(negedge clk);
    end
    drv1(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if (rvalid1[0]) nrv++;
    @(negedge clk);
    chk("stall rvalid count", 32'(nrv), 32'(nacc));
    chk("stall gnt low seen", 32'(saw_low), 32'd1);
    chk("stall idle", 32'(rvalid1[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
